// File: rtl/dmem_store_queue_pkg.sv
// dmem_store_queue_pkg: memory-subsystem load/store width enum and store-buffer entry layout
package dmem_store_queue_pkg;
  localparam int XLEN = 32;
  typedef enum logic [2:0] {
    LS_B  = 3'd0,
    LS_H  = 3'd1,
    LS_W  = 3'd2,
    LS_BU = 3'd3,
    LS_HU = 3'd4
  } ldst_mode_t;
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    ldst_mode_t      mode;
  } store_entry_t;
  function automatic logic word_match(logic [XLEN-1:0] a, logic [XLEN-1:0] b);
    return a[XLEN-1:2] == b[XLEN-1:2];
  endfunction
endpackage

// File: rtl/sq_fwd_match.sv
// sq_fwd_match: youngest-match store-to-load forwarding lookup for one load port
module sq_fwd_match
  import dmem_store_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  store_entry_t     ent_i [DEPTH],
  input  logic [DEPTH-1:0] vld_i,
  input  logic [PTR_W-1:0] head_i,
  input  logic [XLEN-1:0]  ld_addr_i,
  input  ldst_mode_t       ld_mode_i,
  output logic             hit_o,
  output logic [XLEN-1:0]  data_o,
  output logic             stall_o
);
  logic             found;
  logic [PTR_W-1:0] sel, idx;
  // walking oldest to youngest lets the last match win
  always_comb begin
    found = 1'b0;
    sel = '0;
    idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PTR_W'(k);
      if (vld_i[idx] && word_match(ent_i[idx].addr, ld_addr_i)) begin
        found = 1'b1;
        sel = idx;
      end
    end
    hit_o = found && ent_i[sel].mode == LS_W && ld_mode_i == LS_W;
    stall_o = found && !hit_o;
    data_o = hit_o ? ent_i[sel].data : '0;
  end
endmodule

// File: rtl/dmem_store_queue.sv
// dmem_store_queue: two-lane in-order store buffer draining into the data-memory write port, with load forwarding
module dmem_store_queue
  import dmem_store_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ADDR_W = XLEN,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        st_valid,
  output logic [1:0]        st_ready,
  input  logic [ADDR_W-1:0] st_addr [2],
  input  logic [ADDR_W-1:0] st_data [2],
  input  ldst_mode_t        st_mode [2],
  input  logic              drain_en,
  output logic              we,
  output logic [ADDR_W-1:0] wa,
  output logic [ADDR_W-1:0] wd,
  output ldst_mode_t        wm,
  input  logic [ADDR_W-1:0] ld_addr [2],
  input  ldst_mode_t        ld_mode [2],
  output logic [1:0]        fwd_hit,
  output logic [ADDR_W-1:0] fwd_data [2],
  output logic [1:0]        fwd_stall,
  output logic [CNT_W-1:0]  count,
  output logic              empty
);
  store_entry_t     ent_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, slot1;
  logic [CNT_W-1:0] count_q, count_d, free;
  logic [1:0]       push;
  logic             pop;
  // readiness uses the registered count only, so a same-cycle pop never frees a slot
  always_comb begin
    free = CNT_W'(DEPTH) - count_q;
    st_ready[0] = rst_n && free != '0;
    st_ready[1] = rst_n && (free >= CNT_W'(2) || (free != '0 && !st_valid[0]));
    push = st_valid & st_ready;
    slot1 = tail_q + PTR_W'(push[0]);
    empty = count_q == '0;
    pop = !empty && drain_en;
    we = pop;
    wa = empty ? '0 : ent_q[head_q].addr;
    wd = empty ? '0 : ent_q[head_q].data;
    wm = empty ? LS_B : ent_q[head_q].mode;
    head_d = head_q + PTR_W'(pop);
    tail_d = tail_q + PTR_W'(push[0]) + PTR_W'(push[1]);
    count_d = count_q + CNT_W'(push[0]) + CNT_W'(push[1]) - CNT_W'(pop);
    vld_d = vld_q;
    if (pop) vld_d[head_q] = 1'b0;
    if (push[0]) vld_d[tail_q] = 1'b1;
    if (push[1]) vld_d[slot1] = 1'b1;
  end
  assign count = count_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      vld_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      vld_q <= vld_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push[0]) ent_q[tail_q] <= '{addr: st_addr[0], data: st_data[0], mode: st_mode[0]};
    if (push[1]) ent_q[slot1] <= '{addr: st_addr[1], data: st_data[1], mode: st_mode[1]};
  end
  for (genvar p = 0; p < 2; p++) begin : g_fwd
    sq_fwd_match #(.DEPTH(DEPTH)) u_fwd (
      .ent_i    (ent_q),
      .vld_i    (vld_q),
      .head_i   (head_q),
      .ld_addr_i(ld_addr[p]),
      .ld_mode_i(ld_mode[p]),
      .hit_o    (fwd_hit[p]),
      .data_o   (fwd_data[p]),
      .stall_o  (fwd_stall[p])
    );
  end
endmodule

// File: tb/tb_dmem_store_queue.sv
// tb_dmem_store_queue: queue-based reference model checked every cycle, plus directed literal checks
module tb_dmem_store_queue;
  import dmem_store_queue_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [1:0]  st_valid, st_ready, fwd_hit, fwd_stall;
  logic [31:0] st_addr [2], st_data [2], ld_addr [2], fwd_data [2];
  ldst_mode_t  st_mode [2], ld_mode [2], wm;
  logic        drain_en, we, empty;
  logic [31:0] wa, wd;
  logic [2:0]  count;
  int checks = 0, failures = 0;
  typedef struct {logic [31:0] a; logic [31:0] d; ldst_mode_t m;} ent_t;
  ent_t q[$];

  dmem_store_queue #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_mode(st_mode), .drain_en(drain_en),
    .we(we), .wa(wa), .wd(wd), .wm(wm), .ld_addr(ld_addr), .ld_mode(ld_mode),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_stall(fwd_stall),
    .count(count), .empty(empty)
  );

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] m_ready();
    int free;
    free = DEPTH - q.size();
    if (!rst_n) return 2'b00;
    return {free >= 2 || (free >= 1 && !st_valid[0]), free >= 1};
  endfunction

  always @(negedge clk) begin
    int y;
    logic eh, es;
    chk("st_ready", st_ready, m_ready());
    chk("we", we, rst_n && q.size() > 0 && drain_en);
    if (q.size() > 0) begin
      chk("wa", wa, q[0].a);
      chk("wd", wd, q[0].d);
      chk("wm", wm, q[0].m);
    end else begin
      chk("wa_empty", wa, 0);
      chk("wd_empty", wd, 0);
    end
    chk("count", count, q.size());
    chk("empty", empty, q.size() == 0);
    for (int k = 0; k < 2; k++) begin
      y = -1;
      for (int i = q.size() - 1; i >= 0; i--)
        if ((q[i].a >> 2) == (ld_addr[k] >> 2)) begin
          y = i;
          break;
        end
      eh = y >= 0 && q[y].m == LS_W && ld_mode[k] == LS_W;
      es = y >= 0 && !eh;
      chk($sformatf("fwd_hit%0d", k), fwd_hit[k], eh);
      chk($sformatf("fwd_stall%0d", k), fwd_stall[k], es);
      if (!es) chk($sformatf("fwd_data%0d", k), fwd_data[k], eh ? q[y].d : 32'h0);
    end
  end

  always @(posedge clk) begin
    logic [1:0] r;
    if (rst_n) begin
      r = m_ready();
      if (q.size() > 0 && drain_en) void'(q.pop_front());
      if (st_valid[0] && r[0]) q.push_back('{st_addr[0], st_data[0], st_mode[0]});
      if (st_valid[1] && r[1]) q.push_back('{st_addr[1], st_data[1], st_mode[1]});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    st_valid = 2'b00;
    drain_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      st_addr[k] = '0;
      st_data[k] = '0;
      st_mode[k] = LS_B;
      ld_addr[k] = 32'h1000;
      ld_mode[k] = LS_W;
    end
  endtask

  task automatic set_st(int l, logic [31:0] a, logic [31:0] d, ldst_mode_t m);
    st_valid[l] = 1'b1;
    st_addr[l] = a;
    st_data[l] = d;
    st_mode[l] = m;
  endtask

  task automatic drain_all();
    st_valid = 2'b00;
    drain_en = 1'b1;
    repeat (DEPTH + 1) step();
    @(negedge clk);
    chk("drain_empty", empty, 1);
    drain_en = 1'b0;
    step();
  endtask

  initial begin
    idle();
    st_valid = 2'b11;
    q.delete();
    @(negedge clk);
    chk("rst_ready_lit", st_ready, 2'b00);
    chk("rst_empty_lit", empty, 1);
    chk("rst_we_lit", we, 0);
    st_valid = 2'b00;
    step();
    rst_n = 1'b1;
    // single lane-0 store drains the next cycle
    set_st(0, 32'h10, 32'hDEADBEEF, LS_W);
    drain_en = 1'b1;
    step();
    st_valid = 2'b00;
    @(negedge clk);
    chk("t1_we", we, 1);
    chk("t1_wa", wa, 32'h10);
    chk("t1_wd", wd, 32'hDEADBEEF);
    step();
    @(negedge clk);
    chk("t1_empty", empty, 1);
    // fill with both lanes, then drain in program order
    step();
    drain_en = 1'b0;
    set_st(0, 32'h100, 32'h1, LS_W);
    set_st(1, 32'h104, 32'h2, LS_W);
    step();
    set_st(0, 32'h108, 32'h3, LS_W);
    set_st(1, 32'h10C, 32'h4, LS_W);
    step();
    @(negedge clk);
    chk("t2_count", count, 4);
    chk("t2_ready", st_ready, 2'b00);
    step();
    st_valid = 2'b00;
    drain_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_we", we, 1);
      chk("t2_wa", wa, 32'h100 + 32'(4 * i));
      step();
    end
    @(negedge clk);
    chk("t2_empty", empty, 1);
    // three occupied, both lanes valid: only lane 0 accepted, pop balances it
    step();
    drain_en = 1'b0;
    set_st(0, 32'h200, 32'hA, LS_W);
    set_st(1, 32'h204, 32'hB, LS_W);
    step();
    st_valid = 2'b00;
    set_st(0, 32'h208, 32'hC, LS_W);
    step();
    set_st(0, 32'h20C, 32'hD, LS_W);
    set_st(1, 32'h210, 32'hE, LS_W);
    drain_en = 1'b1;
    @(negedge clk);
    chk("t3_ready", st_ready, 2'b01);
    chk("t3_count_before", count, 3);
    step();
    st_valid = 2'b00;
    drain_en = 1'b0;
    @(negedge clk);
    chk("t3_count_after", count, 3);
    drain_all();
    // youngest of two full-word stores forwards
    set_st(0, 32'h20, 32'h1111, LS_W);
    set_st(1, 32'h20, 32'h2222, LS_W);
    step();
    st_valid = 2'b00;
    ld_addr[0] = 32'h20;
    ld_addr[1] = 32'h24;
    @(negedge clk);
    chk("t4_hit0", fwd_hit[0], 1);
    chk("t4_data0", fwd_data[0], 32'h2222);
    chk("t4_hit1", fwd_hit[1], 0);
    chk("t4_stall1", fwd_stall[1], 0);
    drain_all();
    // sub-word store overlap must stall
    set_st(0, 32'h22, 32'hAB, LS_B);
    step();
    st_valid = 2'b00;
    ld_addr[0] = 32'h20;
    ld_mode[0] = LS_W;
    ld_addr[1] = 32'h22;
    ld_mode[1] = LS_B;
    @(negedge clk);
    chk("t5_stall0", fwd_stall[0], 1);
    chk("t5_hit0", fwd_hit[0], 0);
    chk("t5_stall1", fwd_stall[1], 1);
    drain_all();
    ld_addr[0] = 32'h1000;
    ld_addr[1] = 32'h1000;
    ld_mode[1] = LS_W;
    // reset mid-drain discards everything
    set_st(0, 32'h300, 32'h5, LS_W);
    set_st(1, 32'h304, 32'h6, LS_W);
    step();
    st_valid = 2'b00;
    set_st(0, 32'h308, 32'h7, LS_W);
    step();
    st_valid = 2'b00;
    drain_en = 1'b1;
    step();
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("t6_we_async", we, 0);
    chk("t6_empty_async", empty, 1);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_no_write", we, 0);
      step();
    end
    // randomized traffic over a small address window to exercise forwarding
    for (int c = 0; c < 800; c++) begin
      if ($urandom % 200 == 0) begin
        rst_n = 1'b0;
        q.delete();
        step();
        rst_n = 1'b1;
      end
      st_valid = 2'($urandom);
      for (int k = 0; k < 2; k++) begin
        st_addr[k] = 32'h40 | 32'($urandom_range(0, 15));
        st_data[k] = $urandom;
        st_mode[k] = ldst_mode_t'(3'($urandom_range(0, 4)));
        ld_addr[k] = 32'h40 | 32'($urandom_range(0, 19));
        ld_mode[k] = ($urandom % 2 == 0) ? LS_W : ldst_mode_t'(3'($urandom_range(0, 4)));
      end
      drain_en = ($urandom % 4) < 2;
      step();
    end
    idle();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
